cbd48_down: RTL and testbench

- Cascadable synchronous binary down counter; the count-down counterpart of the team's cascadable up counters.
- Supports synchronous preset, clear, parallel load, count enable, borrow-in (BI) and borrow-out (BO).
- BO of one stage drives BI of the next more-significant stage to build wide down counters and programmable dividers.
- Adds a registered underflow pulse and a zero flag for timer and terminal-count use.

---
 rtl/cbd48_down.sv | 83 ++++++++
 tb/tb_cbd48_down.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cbd48_down.sv
// Cascadable synchronous binary down counter with borrow chain, zero flag and underflow pulse.
// Optional auto-reload of the last loaded value on underflow: define CBD48_AUTO_RELOAD_EN.
module cbd48_down #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [WIDTH-1:0] D,
   input  logic             LD,
   input  logic             EN,
   input  logic             BI,
   input  logic             PS,
   input  logic             CS,
   output logic [WIDTH-1:0] Q,
   output logic             BO,
   output logic             ZERO,
   output logic             UF
);

   logic [WIDTH-1:0] q_q, q_d;
   logic             uf_q, uf_d;
   logic             dec;
   logic             at_zero;
   logic [WIDTH-1:0] wrap_val;

`ifdef CBD48_AUTO_RELOAD_EN
   logic [WIDTH-1:0] rld_q, rld_d;
   assign wrap_val = rld_q;
`else
   assign wrap_val = '1;
`endif

   assign at_zero = (q_q == '0);
   assign dec     = BI && EN;

   always_comb begin
      q_d  = q_q;
      uf_d = 1'b0;
`ifdef CBD48_AUTO_RELOAD_EN
      rld_d = rld_q;
`endif
      if (PS) begin
         q_d = '1;
      end else if (CS) begin
         q_d = '0;
      end else if (LD) begin
         q_d = D;
`ifdef CBD48_AUTO_RELOAD_EN
         rld_d = D;
`endif
      end else if (dec) begin
         if (at_zero) begin
            q_d  = wrap_val;
            uf_d = 1'b1;
         end else begin
            q_d = q_q - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         q_q  <= '0;
         uf_q <= 1'b0;
`ifdef CBD48_AUTO_RELOAD_EN
         rld_q <= '0;
`endif
      end else begin
         q_q  <= q_d;
         uf_q <= uf_d;
`ifdef CBD48_AUTO_RELOAD_EN
         rld_q <= rld_d;
`endif
      end
   end

   // Borrow is combinational so a cascade ripples within one cycle.
   assign BO   = dec && at_zero;
   assign ZERO = at_zero;
   assign Q    = q_q;
   assign UF   = uf_q;

endmodule

// File: tb/tb_cbd48_down.sv
// Self-checking bench for cbd48_down: cycle model plus directed literal checks.
module tb_cbd48_down;

   logic       CLK = 1'b0;
   logic       RSTN, LD, EN, BI, PS, CS;
   logic [7:0] D;
   logic [7:0] Q;
   logic       BO, ZERO, UF;

   logic [7:0] lq, hq;
   logic       lbo, hbo, lz, hz, luf, huf;
   logic       ce, c_ld;

   int total = 0;
   int bad   = 0;

   int  mq;
   int  mrld;
   bit  muf;
   bit  mvalid = 0;

   always #5 CLK = ~CLK;

   cbd48_down #(.WIDTH(8)) dut (
      .CLK(CLK), .RSTN(RSTN), .D(D), .LD(LD), .EN(EN), .BI(BI),
      .PS(PS), .CS(CS), .Q(Q), .BO(BO), .ZERO(ZERO), .UF(UF)
   );

   cbd48_down #(.WIDTH(8)) u_lo (
      .CLK(CLK), .RSTN(RSTN), .D(8'h01), .LD(c_ld), .EN(ce), .BI(1'b1),
      .PS(1'b0), .CS(1'b0), .Q(lq), .BO(lbo), .ZERO(lz), .UF(luf)
   );

   cbd48_down #(.WIDTH(8)) u_hi (
      .CLK(CLK), .RSTN(RSTN), .D(8'h01), .LD(c_ld), .EN(ce), .BI(lbo),
      .PS(1'b0), .CS(1'b0), .Q(hq), .BO(hbo), .ZERO(hz), .UF(huf)
   );

   // Behavioural model of the main counter, updated on every rising edge.
   always @(posedge CLK) begin
      if (!RSTN) begin
         mq = 0; muf = 0; mrld = 0; mvalid = 1;
      end else if (mvalid) begin
         muf = 0;
         if (PS) mq = 255;
         else if (CS) mq = 0;
         else if (LD) begin mq = D; mrld = D; end
         else if (BI && EN) begin
            if (mq == 0) begin
               muf = 1;
`ifdef CBD48_AUTO_RELOAD_EN
               mq = mrld;
`else
               mq = 255;
`endif
            end else mq = mq - 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (mvalid) begin
         total++;
         if (Q !== mq[7:0] || ZERO !== (mq == 0) || UF !== muf ||
             BO !== (BI && EN && mq == 0)) begin
            bad++;
            $display("FAIL model t=%0t Q=%h/%h Z=%b UF=%b/%b BO=%b", $time,
                     Q, mq[7:0], ZERO, UF, muf, BO);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic r, input logic ps, input logic cs,
                      input logic ld, input logic [7:0] d,
                      input logic en, input logic bi);
      RSTN = r; PS = ps; CS = cs; LD = ld; D = d; EN = en; BI = bi;
      @(posedge CLK);
      #2;
   endtask

   initial begin
      ce = 0; c_ld = 0;
      // reset wins over preset and load
      drv(0, 1, 0, 1, 8'h55, 1, 1);
      chk("rst_q", Q, 0);
      chk("rst_uf", UF, 0);
      chk("rst_zero", ZERO, 1);
      drv(1, 1, 1, 0, 8'h00, 0, 0);
      chk("ps_over_cs", Q, 8'hFF);

      // load and count
      drv(1, 0, 0, 1, 8'h03, 0, 0);
      chk("ld3", Q, 3);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      chk("cnt2", Q, 2);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      chk("cnt1", Q, 1);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      chk("cnt0", Q, 0);
      chk("bo_at0", BO, 1);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
`ifdef CBD48_AUTO_RELOAD_EN
      chk("wrap", Q, 3);
`else
      chk("wrap", Q, 8'hFF);
`endif
      chk("uf_pulse", UF, 1);
      drv(1, 0, 0, 0, 8'h00, 0, 0);
      chk("uf_clear", UF, 0);

      // gating
      drv(1, 0, 0, 1, 8'h05, 0, 0);
      drv(1, 0, 0, 0, 8'h00, 1, 0);
      chk("gate_en", Q, 5);
      drv(1, 0, 0, 0, 8'h00, 0, 1);
      chk("gate_bi", Q, 5);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      drv(1, 0, 0, 0, 8'h00, 0, 0);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      chk("gate_q", Q, 3);

      // load with count from zero
      drv(1, 0, 1, 0, 8'h00, 0, 0);
      RSTN = 1; PS = 0; CS = 0; LD = 1; D = 8'h7A; EN = 1; BI = 1;
      #1;
      chk("ld_bo_pre", BO, 1);
      @(posedge CLK);
      #2;
      chk("ld_wins", Q, 8'h7A);
      chk("ld_no_uf", UF, 0);

      // reset mid-count
      drv(1, 0, 0, 0, 8'h00, 1, 1);
      drv(0, 0, 0, 0, 8'h00, 1, 1);
      chk("mid_rst", Q, 0);
      drv(1, 0, 0, 0, 8'h00, 1, 1);
`ifdef CBD48_AUTO_RELOAD_EN
      chk("rst_resume", Q, 0);
      chk("rst_resume_bo", BO, 1);
`else
      chk("rst_resume", Q, 8'hFF);
`endif
      chk("rst_resume_uf", UF, 1);

`ifdef CBD48_AUTO_RELOAD_EN
      drv(1, 0, 0, 1, 8'h02, 0, 0);
      for (int i = 0; i < 6; i++) begin
         drv(1, 0, 0, 0, 8'h00, 1, 1);
         chk("arl_q", Q, (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
         chk("arl_uf", UF, (i % 3 == 2) ? 1 : 0);
      end
`endif

      // cascade of two stages
      c_ld = 1; ce = 0;
      drv(1, 0, 0, 0, 8'h00, 0, 0);
      chk("casc0", {hq, lq}, 16'h0101);
      c_ld = 0; ce = 1;
      drv(1, 0, 0, 0, 8'h00, 0, 0);
      chk("casc1", {hq, lq}, 16'h0100);
      drv(1, 0, 0, 0, 8'h00, 0, 0);
`ifdef CBD48_AUTO_RELOAD_EN
      chk("casc2", {hq, lq}, 16'h0001);
`else
      chk("casc2", {hq, lq}, 16'h00FF);
      drv(1, 0, 0, 0, 8'h00, 0, 0);
      chk("casc3", {hq, lq}, 16'h00FE);
`endif
      ce = 0;
      drv(1, 0, 0, 0, 8'h00, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
